lut_loader: RTL and testbench

Writes a lookup table into the block RAM that the delineariser reads. It accepts 16-bit table entries on an AXI4-Stream slave and issues one AXI4-Lite single-beat write per entry (AW/W/B) to the BRAM controller's write port. Entries go to consecutive 16-bit slots, so the entry for input magnitude n lands at byte address BASE_ADDR + 2n. The block sits beside the delineariser on the same BRAM controller and only drives the write channels.

---
 rtl/lut_loader_pkg.sv | 16 +
 rtl/lut_loader_axil_writer.sv | 73 +++++++
 rtl/lut_loader.sv | 138 +++++++++++++
 tb/tb_lut_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_loader_pkg.sv
// Shared types for the LUT loader: FSM states and AXI write-response codes.
package lut_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_WRITE,
    ST_RESP,
    ST_FINISH
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/lut_loader_axil_writer.sv
// One AXI4-Lite single-beat write: AW and W issued together, each dropped on its own
// handshake, then B accepted. All AXI outputs come straight from registers.
module axil_single_writer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_wdone,
  output logic                  o_ack,
  output logic [1:0]            o_resp,
  output logic [ADDR_WIDTH-1:0] o_awaddr,
  output logic                  o_awvalid,
  input  logic                  i_awready,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_wvalid,
  input  logic                  i_wready,
  input  logic [1:0]            i_bresp,
  input  logic                  i_bvalid,
  output logic                  o_bready
);

  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  w_aw_hs;
  logic                  w_w_hs;

  assign w_aw_hs = r_awvalid & i_awready;
  assign w_w_hs  = r_wvalid & i_wready;

  // Fires in the cycle the last outstanding of AW/W completes, whichever order they finish in.
  assign o_wdone = (r_awvalid | r_wvalid) & (~r_awvalid | i_awready) & (~r_wvalid | i_wready);
  assign o_ack   = r_bready & i_bvalid;
  assign o_resp  = i_bresp;

  assign o_awaddr  = r_awaddr;
  assign o_awvalid = r_awvalid;
  assign o_wdata   = r_wdata;
  assign o_wvalid  = r_wvalid;
  assign o_bready  = r_bready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
    end else begin
      if (i_req) begin
        r_awvalid <= 1'b1;
        r_wvalid  <= 1'b1;
        r_awaddr  <= i_addr;
        r_wdata   <= i_data;
      end else begin
        if (w_aw_hs) r_awvalid <= 1'b0;
        if (w_w_hs)  r_wvalid  <= 1'b0;
      end
      if (o_wdone) begin
        r_bready <= 1'b1;
      end else if (o_ack) begin
        r_bready <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/lut_loader.sv
// Streams 16-bit table entries into consecutive BRAM slots, one AXI4-Lite write per entry.
// Aborts on the first error response; stops after DEPTH entries even without tlast.
module lut_loader
  import lut_loader_pkg::*;
#(
  parameter int                  DATA_WIDTH = 16,
  parameter int                  ADDR_WIDTH = 16,
  parameter int                  DEPTH      = 8192,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  localparam int                 CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                  S_AXIS_tvalid,
  output logic                  S_AXIS_tready,
  input  logic                  S_AXIS_tlast,
  output logic [ADDR_WIDTH-1:0] BRAM_AXI_awaddr,
  output logic                  BRAM_AXI_awvalid,
  input  logic                  BRAM_AXI_awready,
  output logic [DATA_WIDTH-1:0] BRAM_AXI_wdata,
  output logic                  BRAM_AXI_wvalid,
  input  logic                  BRAM_AXI_wready,
  input  logic [1:0]            BRAM_AXI_bresp,
  input  logic                  BRAM_AXI_bvalid,
  output logic                  BRAM_AXI_bready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CNT_W-1:0]      count
);

  state_t                r_state;
  logic                  r_tready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic                  r_last;
  logic [CNT_W-1:0]      r_count;

  logic                  w_beat;
  logic                  w_wdone;
  logic                  w_ack;
  logic [1:0]            w_resp;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_beat = r_tready & S_AXIS_tvalid;
  // The count of good writes doubles as the slot index of the next entry.
  assign w_addr = BASE_ADDR + ADDR_WIDTH'({r_count, 1'b0});

  assign S_AXIS_tready = r_tready;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign count         = r_count;

  axil_single_writer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_writer (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_beat),
    .i_addr    (w_addr),
    .i_data    (S_AXIS_tdata),
    .o_wdone   (w_wdone),
    .o_ack     (w_ack),
    .o_resp    (w_resp),
    .o_awaddr  (BRAM_AXI_awaddr),
    .o_awvalid (BRAM_AXI_awvalid),
    .i_awready (BRAM_AXI_awready),
    .o_wdata   (BRAM_AXI_wdata),
    .o_wvalid  (BRAM_AXI_wvalid),
    .i_wready  (BRAM_AXI_wready),
    .i_bresp   (BRAM_AXI_bresp),
    .i_bvalid  (BRAM_AXI_bvalid),
    .o_bready  (BRAM_AXI_bready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_tready <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_last   <= 1'b0;
      r_count  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_count  <= '0;
            r_error  <= 1'b0;
            r_busy   <= 1'b1;
            r_tready <= 1'b1;
            r_state  <= ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          if (w_beat) begin
            r_tready <= 1'b0;
            r_last   <= S_AXIS_tlast;
            r_state  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (w_wdone) r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (w_ack) begin
            if (w_resp != RESP_OKAY) begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_FINISH;
            end else begin
              r_count <= r_count + 1'b1;
              if (r_last || (r_count == CNT_W'(DEPTH - 1))) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_FINISH;
              end else begin
                r_tready <= 1'b1;
                r_state  <= ST_ACCEPT;
              end
            end
          end
        end
        ST_FINISH: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_loader.sv
// Bench for lut_loader: a negedge-driven AXI-Stream source and AXI4-Lite BRAM slave feed
// two instances (full depth and depth 4); results are compared to a table-level model.
module tb_lut_loader;
  import lut_loader_pkg::*;

  localparam int DEPTH_A = 8192;
  localparam int DEPTH_B = 4;
  localparam int CW_A    = $clog2(DEPTH_A + 1);
  localparam int CW_B    = $clog2(DEPTH_B + 1);

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b, sel;
  logic [15:0] tdata;
  logic        tvalid, tlast, awready, wready, bvalid;
  logic [1:0]  bresp;

  logic            a_tready, a_awvalid, a_wvalid, a_bready, a_busy, a_done, a_error;
  logic [15:0]     a_awaddr, a_wdata;
  logic [CW_A-1:0] a_count;
  logic            b_tready, b_awvalid, b_wvalid, b_bready, b_busy, b_done, b_error;
  logic [15:0]     b_awaddr, b_wdata;
  logic [CW_B-1:0] b_count;

  lut_loader #(.DEPTH(DEPTH_A)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .S_AXIS_tdata(tdata), .S_AXIS_tvalid(tvalid), .S_AXIS_tready(a_tready), .S_AXIS_tlast(tlast),
    .BRAM_AXI_awaddr(a_awaddr), .BRAM_AXI_awvalid(a_awvalid), .BRAM_AXI_awready(awready),
    .BRAM_AXI_wdata(a_wdata), .BRAM_AXI_wvalid(a_wvalid), .BRAM_AXI_wready(wready),
    .BRAM_AXI_bresp(bresp), .BRAM_AXI_bvalid(bvalid), .BRAM_AXI_bready(a_bready),
    .busy(a_busy), .done(a_done), .error(a_error), .count(a_count)
  );

  lut_loader #(.DEPTH(DEPTH_B)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .S_AXIS_tdata(tdata), .S_AXIS_tvalid(tvalid), .S_AXIS_tready(b_tready), .S_AXIS_tlast(tlast),
    .BRAM_AXI_awaddr(b_awaddr), .BRAM_AXI_awvalid(b_awvalid), .BRAM_AXI_awready(awready),
    .BRAM_AXI_wdata(b_wdata), .BRAM_AXI_wvalid(b_wvalid), .BRAM_AXI_wready(wready),
    .BRAM_AXI_bresp(bresp), .BRAM_AXI_bvalid(bvalid), .BRAM_AXI_bready(b_bready),
    .busy(b_busy), .done(b_done), .error(b_error), .count(b_count)
  );

  // The idle instance never raises valid/ready, so the shared slave only ever talks to sel.
  logic        m_tready, m_awvalid, m_wvalid, m_bready, m_busy, m_done, m_error;
  logic [15:0] m_awaddr, m_wdata;
  logic [31:0] m_count;
  assign m_tready  = sel ? b_tready  : a_tready;
  assign m_awvalid = sel ? b_awvalid : a_awvalid;
  assign m_wvalid  = sel ? b_wvalid  : a_wvalid;
  assign m_bready  = sel ? b_bready  : a_bready;
  assign m_busy    = sel ? b_busy    : a_busy;
  assign m_done    = sel ? b_done    : a_done;
  assign m_error   = sel ? b_error   : a_error;
  assign m_awaddr  = sel ? b_awaddr  : a_awaddr;
  assign m_wdata   = sel ? b_wdata   : a_wdata;
  assign m_count   = sel ? 32'(b_count) : 32'(a_count);

  int checks = 0;
  int errors = 0;

  wr_t         wr_log[$];
  wr_t         exp_w[$];
  logic [16:0] src_q[$];
  logic [15:0] ent_q[$];
  bit          lst_q[$];
  int          dly_aw[32], dly_w[32];
  logic [1:0]  resp_tab[32];
  int  cyc = 0, c0 = 0, done_cnt = 0, done_cyc = 0, accepted = 0, aw_hs = 0, wr_idx = 0;
  int  aw_cnt = 0, w_cnt = 0, mid_start_at = -1;
  bit  aw_got, w_got, b_pend, t_hold, gaps, p_aw_wait, p_w_wait;
  logic [15:0] cur_addr, cur_data, p_awaddr, p_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic clear_slave();
    aw_cnt = 0; w_cnt = 0; aw_got = 0; w_got = 0; b_pend = 0; wr_idx = 0;
    p_aw_wait = 0; p_w_wait = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
  endtask

  task automatic clear_src();
    src_q.delete(); tvalid = 0; tlast = 0; tdata = '0; t_hold = 0;
  endtask

  // One clock: observe outputs at the falling edge, then set inputs for the next rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (m_done) begin done_cnt++; done_cyc = cyc; end
    if (p_aw_wait) begin
      chk("awvalid_hold", m_awvalid, 1);
      chk("awaddr_stable", m_awaddr, p_awaddr);
    end
    if (p_w_wait) begin
      chk("wvalid_hold", m_wvalid, 1);
      chk("wdata_stable", m_wdata, p_wdata);
    end
    bvalid = b_pend;
    bresp  = b_pend ? resp_tab[wr_idx % 32] : 2'b00;
    if (bvalid && m_bready) begin
      wr_log.push_back('{addr: cur_addr, data: cur_data});
      b_pend = 0; aw_got = 0; w_got = 0; wr_idx++;
    end
    awready = 0;
    if (m_awvalid) begin
      awready = (aw_cnt >= dly_aw[wr_idx % 32]);
      if (awready) begin cur_addr = m_awaddr; aw_got = 1; aw_cnt = 0; aw_hs++; end
      else aw_cnt++;
    end
    wready = 0;
    if (m_wvalid) begin
      wready = (w_cnt >= dly_w[wr_idx % 32]);
      if (wready) begin cur_data = m_wdata; w_got = 1; w_cnt = 0; end
      else w_cnt++;
    end
    if (aw_got && w_got && !b_pend) b_pend = 1;
    p_aw_wait = m_awvalid && !awready; p_awaddr = m_awaddr;
    p_w_wait  = m_wvalid && !wready;   p_wdata  = m_wdata;
    if (!t_hold) tvalid = (src_q.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
    if (tvalid) begin tdata = src_q[0][15:0]; tlast = src_q[0][16]; end
    if (tvalid && m_tready) begin
      void'(src_q.pop_front()); accepted++; t_hold = 0;
    end else begin
      t_hold = tvalid;
    end
  endtask

  task automatic prepare(input int n, input int last_at, input bit fixed);
    ent_q.delete(); lst_q.delete();
    for (int i = 0; i < n; i++) begin
      logic [15:0] v;
      v = fixed ? 16'(i + 1) : 16'($urandom);
      ent_q.push_back(v);
      lst_q.push_back(i == last_at);
      src_q.push_back({(i == last_at) ? 1'b1 : 1'b0, v});
    end
  endtask

  task automatic run_load(input int budget);
    wr_log.delete(); aw_hs = 0; accepted = 0; done_cnt = 0;
    clear_slave();
    chk("idle_busy", m_busy, 0);
    set_start(1); c0 = cyc; tick(); set_start(0);
    chk("busy_rise", m_busy, 1);
    for (int k = 0; k < budget && done_cnt == 0; k++) begin
      if (k == mid_start_at) set_start(1);
      tick();
      set_start(0);
    end
    chk("done_seen", done_cnt, 1);
    chk("busy_at_done", m_busy, 0);
  endtask

  // Table-level model: entry i goes to 2*i; stop at tlast, DEPTH, or the first bad response.
  task automatic verify(input string tag, input int depth);
    int cnt; bit err;
    exp_w.delete(); cnt = 0; err = 0;
    for (int i = 0; i < ent_q.size(); i++) begin
      if (i == depth) break;
      exp_w.push_back('{addr: 16'(2 * i), data: ent_q[i]});
      if (resp_tab[i] != RESP_OKAY) begin err = 1; break; end
      cnt++;
      if (lst_q[i]) break;
    end
    repeat (4) tick();
    chk({tag, "_nwrites"}, wr_log.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < wr_log.size(); i++) begin
      chk({tag, "_addr"}, wr_log[i].addr, exp_w[i].addr);
      chk({tag, "_data"}, wr_log[i].data, exp_w[i].data);
    end
    chk({tag, "_count"}, m_count, cnt);
    chk({tag, "_error"}, m_error, err);
    chk({tag, "_aw_issued"}, aw_hs, exp_w.size());
    chk({tag, "_accepted"}, accepted, exp_w.size());
    chk({tag, "_one_done"}, done_cnt, 1);
    chk({tag, "_tready_idle"}, m_tready, 0);
    chk({tag, "_awvalid_idle"}, m_awvalid, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tready"}, a_tready, 0);
    chk({tag, "_awvalid"}, a_awvalid, 0);
    chk({tag, "_wvalid"}, a_wvalid, 0);
    chk({tag, "_bready"}, a_bready, 0);
    chk({tag, "_awaddr"}, a_awaddr, 0);
    chk({tag, "_wdata"}, a_wdata, 0);
    chk({tag, "_busy"}, a_busy, 0);
    chk({tag, "_done"}, a_done, 0);
    chk({tag, "_error"}, a_error, 0);
    chk({tag, "_count"}, 32'(a_count), 0);
  endtask

  initial begin
    rst = 1; sel = 0; start_a = 0; start_b = 0; gaps = 0;
    for (int i = 0; i < 32; i++) begin dly_aw[i] = 0; dly_w[i] = 0; resp_tab[i] = RESP_OKAY; end
    clear_slave(); clear_src();
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst = 0;
    tick();

    // Four fixed entries, all readies immediate.
    prepare(4, 3, 1);
    run_load(60);
    chk("t1_done_cycle", done_cyc - c0, 13);
    verify("t1", DEPTH_A);

    // Skewed AW/W readiness, then random delays and stream gaps, with a start while busy.
    dly_aw[0] = 2; dly_w[0] = 0; dly_aw[1] = 0; dly_w[1] = 3;
    for (int i = 2; i < 32; i++) begin dly_aw[i] = $urandom_range(0, 4); dly_w[i] = $urandom_range(0, 4); end
    gaps = 1; mid_start_at = 4;
    prepare(7, 6, 0);
    run_load(300);
    verify("t2", DEPTH_A);
    gaps = 0; mid_start_at = -1;
    for (int i = 0; i < 32; i++) begin dly_aw[i] = 0; dly_w[i] = 0; end

    // Slave error on the second write aborts the load.
    resp_tab[1] = RESP_SLVERR;
    prepare(4, 3, 0);
    run_load(60);
    verify("t3", DEPTH_A);
    chk("t3_left_in_stream", src_q.size(), 2);
    resp_tab[1] = RESP_OKAY;
    clear_src();

    // Depth-4 instance fed six entries with no tlast.
    sel = 1;
    prepare(6, -1, 0);
    run_load(60);
    verify("t4", DEPTH_B);
    chk("t4_left_in_stream", src_q.size(), 2);
    clear_src();
    sel = 0;
    tick();

    // Reset while the second entry is in its write phase.
    prepare(3, 2, 0);
    wr_log.delete(); aw_hs = 0; accepted = 0; done_cnt = 0;
    clear_slave();
    set_start(1); tick(); set_start(0);
    for (int k = 0; k < 40 && !(wr_idx == 1 && m_awvalid); k++) tick();
    chk("t5_reached_write2", m_awvalid, 1);
    chk("t5_write2_addr", m_awaddr, 16'h0002);
    rst = 1;
    #1;
    chk_reset("t5_rst");
    clear_slave(); clear_src();
    tick();
    rst = 0;
    tick();
    prepare(2, 1, 0);
    run_load(60);
    verify("t5_reload", DEPTH_A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
